// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle of FIFO read-side and output-stream signals for fifo_rd_stream_adapter.
// master = the adapter, slave = whatever drives the FIFO/stream/control side.
interface fifo_rd_stream_adapter_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 16
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_pop;
   logic              enable;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              flush_busy;
   logic [CNT_W-1:0]  beat_count;

   modport master (
      input  fifo_empty, fifo_dout, enable, flush, out_ready,
      output fifo_pop, out_valid, out_data, out_last, flush_busy, beat_count
   );

   modport slave (
      output fifo_empty, fifo_dout, enable, flush, out_ready,
      input  fifo_pop, out_valid, out_data, out_last, flush_busy, beat_count
   );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// FWFT FIFO read port to registered valid/ready stream: 2-entry skid buffer,
// packet framing, flush/drain FSM and delivered-beat counter.
module fifo_rd_stream_adapter #(
   parameter int DATA_W  = 3,
   parameter int PKT_LEN = 4,
   parameter int CNT_W   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   fifo_rd_stream_adapter_if.master      bus
);
   localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              occ_q, occ_d;
   logic [1:0][DATA_W-1:0]  data_q, data_d;
   logic [1:0]              last_q, last_d;
   logic [IDX_W-1:0]        pkt_idx_q, pkt_idx_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic                    pop, capture, hs, valid;
   logic [1:0]              occ_tmp;

   // Pop depends only on registered state and the FIFO flag, never on out_ready.
   always_comb begin
      pop     = ((state_q == RUN) && !bus.fifo_empty && (occ_q < 2'd2)) ||
                ((state_q == FLUSH) && !bus.fifo_empty);
      capture = pop && (state_q == RUN);
      valid   = (occ_q != 2'd0) && (state_q != FLUSH);
      hs      = valid && bus.out_ready;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = FLUSH;
      end else begin
         unique case (state_q)
            IDLE:    if (bus.enable) state_d = RUN;
            RUN:     if (!bus.enable) state_d = IDLE;
            FLUSH:   if (bus.fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      data_d     = data_q;
      last_d     = last_q;
      occ_d      = occ_q;
      pkt_idx_d  = pkt_idx_q;
      beat_cnt_d = hs ? beat_cnt_q + 1'b1 : beat_cnt_q;
      occ_tmp    = occ_q;
      if (bus.flush) begin
         // A beat accepted on the flush edge still counts; everything else is dropped.
         occ_d     = 2'd0;
         pkt_idx_d = '0;
      end else begin
         if (hs) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
            occ_tmp   = occ_q - 2'd1;
         end
         if (capture) begin
            data_d[occ_tmp[0]] = bus.fifo_dout;
            last_d[occ_tmp[0]] = (pkt_idx_q == LAST_IDX);
            occ_tmp            = occ_tmp + 2'd1;
            pkt_idx_d          = (pkt_idx_q == LAST_IDX) ? '0 : pkt_idx_q + 1'b1;
         end
         occ_d = occ_tmp;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         occ_q      <= 2'd0;
         data_q     <= '0;
         last_q     <= '0;
         pkt_idx_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         data_q     <= data_d;
         last_q     <= last_d;
         pkt_idx_q  <= pkt_idx_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.fifo_pop   = pop;
   assign bus.out_valid  = valid;
   assign bus.out_data   = data_q[0];
   assign bus.out_last   = last_q[0];
   assign bus.flush_busy = (state_q == FLUSH);
   assign bus.beat_count = beat_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: behavioural FWFT FIFO with registered empty flag feeding the
// adapter, stream monitor, and hand-computed expectations.
module tb_fifo_rd_stream_adapter;
   localparam int DW = 8;
   localparam int CW = 16;

   logic clk;
   logic reset;

   fifo_rd_stream_adapter_if #(.DATA_W(DW), .CNT_W(CW)) ifc ();

   fifo_rd_stream_adapter #(.DATA_W(DW), .PKT_LEN(4), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // FIFO model: stimulus appends at wr_cnt, model pops at rd_ptr.
   logic [DW-1:0] wr_mem [256];
   int wr_cnt    = 0;
   int rd_ptr    = 0;
   int pop_total = 0;
   int pop_err   = 0;

   always @(posedge clk) begin
      if (ifc.fifo_pop) begin
         if (ifc.fifo_empty) pop_err++;
         else rd_ptr = rd_ptr + 1;
         pop_total++;
      end
      ifc.fifo_empty <= (rd_ptr == wr_cnt);
      ifc.fifo_dout  <= wr_mem[rd_ptr[7:0]];
   end

   logic [DW-1:0] rx_data [64];
   logic          rx_last [64];
   int rx_n = 0;

   always @(posedge clk) begin
      if (ifc.out_valid && ifc.out_ready && rx_n < 64) begin
         rx_data[rx_n] = ifc.out_data;
         rx_last[rx_n] = ifc.out_last;
         rx_n++;
      end
   end

   task automatic push(input logic [DW-1:0] v);
      @(negedge clk);
      wr_mem[wr_cnt[7:0]] = v;
      wr_cnt++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rx(input string tag, input int n);
      int b = 0;
      while (rx_n < n && b < 200) begin
         @(negedge clk);
         b++;
      end
      check(tag, rx_n, n);
   endtask

   task automatic wait_flush_done(input string tag);
      int b = 0;
      while (ifc.flush_busy && b < 100) begin
         check({tag, "_valid_low"}, ifc.out_valid, 0);
         @(negedge clk);
         b++;
      end
      check({tag, "_exit"}, ifc.flush_busy, 0);
   endtask

   initial begin
      int p0;
      int bc0;
      int k;
      int b;
      logic [31:0] d_hold;
      reset         = 1'b0;
      ifc.enable    = 1'b0;
      ifc.flush     = 1'b0;
      ifc.out_ready = 1'b0;
      tick(3);
      check("rst_valid", ifc.out_valid, 0);
      check("rst_data", ifc.out_data, 0);
      check("rst_last", ifc.out_last, 0);
      check("rst_pop", ifc.fifo_pop, 0);
      check("rst_busy", ifc.flush_busy, 0);
      check("rst_count", ifc.beat_count, 0);
      reset = 1'b1;
      tick(1);

      // Flow-through 1..5
      ifc.enable = 1'b1;
      ifc.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) push(DW'(i));
      wait_rx("flow_n", 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("flow_data%0d", i), rx_data[i], i + 1);
         check($sformatf("flow_last%0d", i), rx_last[i], (i == 3) ? 1 : 0);
      end
      check("flow_count", ifc.beat_count, 5);

      // Backpressure: 6 words, out_ready low
      ifc.out_ready = 1'b0;
      p0 = pop_total;
      for (int i = 0; i < 6; i++) push(DW'(11 + i));
      tick(5);
      check("bp_data_mid", ifc.out_data, 11);
      tick(5);
      check("bp_pops", pop_total - p0, 2);
      check("bp_valid", ifc.out_valid, 1);
      check("bp_data", ifc.out_data, 11);
      ifc.out_ready = 1'b1;
      wait_rx("bp_n", 11);
      for (int i = 0; i < 6; i++) check($sformatf("bp_rx%0d", i), rx_data[5 + i], 11 + i);
      check("bp_last13", rx_last[7], 1);
      check("bp_last14", rx_last[8], 0);
      check("bp_count", ifc.beat_count, 11);

      // Flush with 2 buffered + 3 in FIFO
      ifc.out_ready = 1'b0;
      p0 = pop_total;
      for (int i = 0; i < 5; i++) push(DW'(21 + i));
      tick(4);
      check("fl_pre_pops", pop_total - p0, 2);
      check("fl_pre_valid", ifc.out_valid, 1);
      ifc.flush = 1'b1;
      tick(1);
      ifc.flush = 1'b0;
      check("fl_busy", ifc.flush_busy, 1);
      wait_flush_done("fl");
      check("fl_empty", ifc.fifo_empty, 1);
      check("fl_pops", pop_total - p0, 5);
      check("fl_count", ifc.beat_count, 11);
      check("fl_rx_n", rx_n, 11);

      // Toggled ready over 8 words, framing restarts after flush
      k = 0;
      b = 0;
      while (rx_n < 19 && b < 100) begin
         @(negedge clk);
         if (k < 8) begin
            wr_mem[wr_cnt[7:0]] = DW'(31 + k);
            wr_cnt++;
            k++;
         end
         ifc.out_ready = ~ifc.out_ready;
         b++;
      end
      check("tg_n", rx_n, 19);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tg_data%0d", i), rx_data[11 + i], 31 + i);
         check($sformatf("tg_last%0d", i), rx_last[11 + i], (i == 3 || i == 7) ? 1 : 0);
      end
      check("tg_count", ifc.beat_count, 19);
      check("tg_pop_empty", pop_err, 0);

      // Enable drop with occ=2
      ifc.out_ready = 1'b0;
      tick(2);
      p0 = pop_total;
      for (int i = 0; i < 3; i++) push(DW'(41 + i));
      tick(4);
      check("en_pre_pops", pop_total - p0, 2);
      ifc.enable = 1'b0;
      p0 = pop_total;
      tick(5);
      check("en_no_pops", pop_total - p0, 0);
      ifc.out_ready = 1'b1;
      wait_rx("en_drain_n", 21);
      check("en_rx41", rx_data[19], 41);
      check("en_rx42", rx_data[20], 42);
      tick(2);
      check("en_idle_valid", ifc.out_valid, 0);
      check("en_fifo_kept", ifc.fifo_empty, 0);
      check("en_idle_pops", pop_total - p0, 0);
      ifc.enable = 1'b1;
      wait_rx("en_resume_n", 22);
      check("en_rx43", rx_data[21], 43);
      check("en_last43", rx_last[21], 0);
      push(DW'(44));
      wait_rx("en_n44", 23);
      check("en_rx44", rx_data[22], 44);
      check("en_last44", rx_last[22], 1);
      check("en_count", ifc.beat_count, 23);

      // Flush sampled together with a handshake
      bc0 = 23;
      push(DW'(51));
      push(DW'(52));
      b = 0;
      while (!ifc.out_valid && b < 20) begin
         @(negedge clk);
         b++;
      end
      check("hf_valid", ifc.out_valid, 1);
      ifc.flush = 1'b1;
      tick(1);
      ifc.flush = 1'b0;
      wait_flush_done("hf");
      check("hf_count", ifc.beat_count, bc0 + 1);
      check("hf_rx_n", rx_n, 24);
      check("hf_rx51", rx_data[23], 51);

      // Asynchronous reset mid-stream
      ifc.out_ready = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) push(DW'(61 + i));
      tick(4);
      check("ar_pre_valid", ifc.out_valid, 1);
      check("ar_pre_data", ifc.out_data, 61);
      #2;
      reset = 1'b0;
      #1;
      check("ar_valid", ifc.out_valid, 0);
      check("ar_pop", ifc.fifo_pop, 0);
      check("ar_last", ifc.out_last, 0);
      check("ar_busy", ifc.flush_busy, 0);
      check("ar_count", ifc.beat_count, 0);
      check("ar_data", ifc.out_data, 0);
      tick(2);
      reset = 1'b1;
      tick(2);
      check("pop_when_empty", pop_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer of the asynchronous FIFO, clocked in the FIFO read-clock domain. Converts the FIFO's first-word-fall-through Pop/DataOut/empty interface into a registered valid/ready stream. The stream carries a 2-entry skid buffer, packet framing (out_last every PKT_LEN beats), a flush/drain state machine and a delivered-beat counter.

Parameters:
DATA_W, 3, data width; equals the FIFO DataSize.
PKT_LEN, 4, beats per packet; out_last is asserted on beat PKT_LEN-1. Legal range is 1 or more.
CNT_W, 16, width of beat_count.

Ports:
clk  input  1  clock; same clock as the FIFO read side (Rclk).
reset  input  1  reset, asynchronous, active-low.
fifo_empty  input  1  FIFO empty flag (registered, FIFO side).
fifo_dout  input  DATA_W  FIFO head data; valid whenever fifo_empty=0.
fifo_pop  output  1  FIFO Pop; combinational from registered state and fifo_empty.
enable  input  1  when 1, the block fetches from the FIFO.
flush  input  1  request to discard buffered data and drain the FIFO.
out_valid  output  1  stream valid.
out_ready  input  1  stream ready.
out_data  output  DATA_W  stream data.
out_last  output  1  last beat of a packet; qualified by out_valid.
flush_busy  output  1  high while in the FLUSH state.
beat_count  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, occupancy occ=0, pkt_idx=0, beat_count=0.
  - Outputs: out_valid=0, out_data=0, out_last=0, fifo_pop=0, flush_busy=0.
- States: IDLE, RUN, FLUSH. All transitions are sampled on the rising edge of clk.
  - IDLE -> RUN when enable=1 and flush=0.
  - RUN -> IDLE when enable=0 and flush=0.
  - Any state -> FLUSH when flush=1.
  - FLUSH -> IDLE when flush=0 and fifo_empty=1 in the same cycle.
- Capture:
  - fifo_pop = (state==RUN and fifo_empty=0 and occ<2), or (state==FLUSH and fifo_empty=0).
  - fifo_pop has no combinational path from out_ready.
  - In RUN, fifo_dout is written into the buffer on the same edge that fifo_pop is high. The write goes to the tail entry, together with last = (pkt_idx==PKT_LEN-1).
  - pkt_idx increments on each RUN capture and wraps from PKT_LEN-1 to 0.
- Output:
  - out_valid = (occ!=0) and state!=FLUSH.
  - out_data and out_last are driven from the head entry registers.
  - In IDLE, entries already buffered still drain to the output; no new fetches are made.
  - Once out_valid=1, out_data and out_last stay stable until out_valid=1 and out_ready=1 (handshake).
- Occupancy:
  - A handshake removes the head entry; entry1 shifts to entry0.
  - Capture and handshake in the same cycle: occ is unchanged, the order is preserved and the new word goes to the tail.
  - occ never exceeds 2 and never underflows.
  - Sustained throughput is 1 beat/clk with out_ready held at 1. occ stays at 1 in steady state.
- beat_count:
  - Increments by 1 on each handshake and wraps modulo 2^CNT_W.
  - Only reset clears it; flush does not.
- FLUSH:
  - On entry, occ is cleared to 0 and pkt_idx to 0 on the next edge. Buffered data is discarded and not counted.
  - Popped words are discarded.
  - While in FLUSH: flush_busy=1, out_valid=0.
  - Because fifo_empty is a registered FIFO flag, the block keeps popping until that flag reads 1.
  - flush held high keeps the block in FLUSH even when the FIFO is empty.
- A pending handshake when flush is sampled: a beat accepted in that same cycle is counted. Subsequent beats are discarded.
- Reset mid-packet: all state returns to its reset values, including pkt_idx=0.
- The block never issues fifo_pop while fifo_empty=1.

Test Plan:
- Flow-through: enable=1, out_ready=1; write words 1,2,3,4,5 into the FIFO -> out_data 1,2,3,4,5 on consecutive handshakes. out_last=1 on the beat with value 4 only. beat_count=5.
- Backpressure: fill the FIFO with 6 words, out_ready=0 for 10 cycles -> exactly 2 pops, out_valid=1, out_data stable at word1. Release out_ready -> words 1..6 arrive in order with no loss or duplicate.
- Toggled ready: out_ready alternates 1/0 every cycle over 8 words -> each word is delivered exactly once and in order. out_last is on beats 4 and 8. fifo_pop is never high while fifo_empty=1.
- Enable drop: deassert enable with occ=2 -> no further pops; both buffered words still drain; state=IDLE. Reassert enable -> fetching resumes at the next FIFO word, and pkt_idx continues without restarting.
- Flush: with 2 words buffered and 3 in the FIFO, pulse flush for 1 cycle -> out_valid=0 and flush_busy=1 until the FIFO is empty; fifo_empty=1 at exit; beat_count unchanged. The first beat after re-enable has pkt_idx 0, so out_last lands on the 4th delivered beat.
- Reset mid-stream: assert reset with out_valid=1 -> out_valid, fifo_pop, out_last, flush_busy and beat_count are all 0 immediately (asynchronous, not waiting for clk).
